// File: rtl/fpnew_rob.sv
// Client-side reorder buffer for the FPU: issues requests with a local tag,
// captures out-of-order results and releases them to the client in issue order.
module fpnew_rob #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAYLOAD_W = 256,
    parameter int unsigned TAG_W     = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [PAYLOAD_W-1:0] req_payload_i,
    output logic                 fpu_valid_o,
    input  logic                 fpu_ready_i,
    output logic [PAYLOAD_W-1:0] fpu_payload_o,
    output logic [TAG_W-1:0]     fpu_tag_o,
    output logic                 fpu_flush_o,
    input  logic                 fpu_rsp_valid_i,
    output logic                 fpu_rsp_ready_o,
    input  logic [WIDTH-1:0]     fpu_result_i,
    input  logic [4:0]           fpu_status_i,
    input  logic [TAG_W-1:0]     fpu_tag_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [WIDTH-1:0]     rsp_result_o,
    output logic [4:0]           rsp_status_o,
    output logic [TAG_W:0]       count_o,
    output logic                 busy_o,
    output logic                 tag_err_o
);

    localparam logic [TAG_W:0]   DEPTH_C = (TAG_W+1)'(DEPTH);
    localparam logic [DEPTH-1:0] ONEHOT0 = DEPTH'(1);

    logic [TAG_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_upd, rptr_upd;
    logic [TAG_W:0]   count_q, count_d, count_upd;
    logic [DEPTH-1:0] pending_q, pending_d, done_q, done_d, pending_upd, done_upd;
    logic [DEPTH-1:0] issue_mask, cap_mask, out_mask;
    logic             tag_err_q, tag_err_d;
    logic [WIDTH-1:0] result_q [DEPTH];
    logic [4:0]       status_q [DEPTH];
    logic             full_s, issue_s, capture_s, miss_s, out_s;

    // Issue path stays combinational; fpu_valid_o never looks at fpu_ready_i.
    assign full_s        = (count_q == DEPTH_C);
    assign fpu_valid_o   = req_valid_i & ~full_s & ~flush_i & ~rst_i;
    assign req_ready_o   = fpu_ready_i & ~full_s & ~flush_i & ~rst_i;
    assign fpu_payload_o = req_payload_i;
    assign fpu_tag_o     = wptr_q;
    assign fpu_flush_o   = flush_i;
    assign fpu_rsp_ready_o = 1'b1;

    assign rsp_valid_o  = done_q[rptr_q] & ~flush_i & ~rst_i;
    assign rsp_result_o = result_q[rptr_q];
    assign rsp_status_o = status_q[rptr_q];
    assign count_o      = count_q;
    assign busy_o       = (count_q != {(TAG_W+1){1'b0}});
    assign tag_err_o    = tag_err_q;

    assign issue_s   = fpu_valid_o & fpu_ready_i;
    assign capture_s = fpu_rsp_valid_i & ~flush_i & pending_q[fpu_tag_i];
    assign miss_s    = fpu_rsp_valid_i & ~flush_i & ~pending_q[fpu_tag_i];
    assign out_s     = rsp_valid_o & rsp_ready_i;

    assign issue_mask  = issue_s   ? (ONEHOT0 << wptr_q)    : {DEPTH{1'b0}};
    assign cap_mask    = capture_s ? (ONEHOT0 << fpu_tag_i) : {DEPTH{1'b0}};
    assign out_mask    = out_s     ? (ONEHOT0 << rptr_q)    : {DEPTH{1'b0}};
    assign pending_upd = (pending_q | issue_mask) & ~cap_mask;
    assign done_upd    = (done_q | cap_mask) & ~out_mask;
    assign wptr_upd    = wptr_q + TAG_W'(issue_s);
    assign rptr_upd    = rptr_q + TAG_W'(out_s);
    assign count_upd   = count_q + (TAG_W+1)'(issue_s) - (TAG_W+1)'(out_s);

    // Next-state selection: a flush drops every entry and rewinds both pointers.
    always_comb begin
        tag_err_d = tag_err_q | miss_s;
        if (flush_i) begin
            pending_d = {DEPTH{1'b0}};
            done_d    = {DEPTH{1'b0}};
            wptr_d    = {TAG_W{1'b0}};
            rptr_d    = {TAG_W{1'b0}};
            count_d   = {(TAG_W+1){1'b0}};
        end else begin
            pending_d = pending_upd;
            done_d    = done_upd;
            wptr_d    = wptr_upd;
            rptr_d    = rptr_upd;
            count_d   = count_upd;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= {DEPTH{1'b0}};
            done_q    <= {DEPTH{1'b0}};
            wptr_q    <= {TAG_W{1'b0}};
            rptr_q    <= {TAG_W{1'b0}};
            count_q   <= {(TAG_W+1){1'b0}};
            tag_err_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            done_q    <= done_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            tag_err_q <= tag_err_d;
        end
    end

    // Result storage; validity is tracked by done_q so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (capture_s) begin
            result_q[fpu_tag_i] <= fpu_result_i;
            status_q[fpu_tag_i] <= fpu_status_i;
        end
    end

endmodule

// File: tb/tb_fpnew_rob.sv
// Self-checking bench for fpnew_rob: directed vector table, hand sequences and
// random traffic, all compared against a queue-based in-order model.
module tb_fpnew_rob;

    localparam int DEPTH = 4;
    localparam int PW    = 16;

    logic          clk;
    logic          rst, flush, req_valid, fpu_ready, fpu_rsp_valid, rsp_ready;
    logic [PW-1:0] payload;
    logic [1:0]    ftag;
    logic [63:0]   fres;
    logic [4:0]    fst;

    logic          req_ready_o, fpu_valid_o, fpu_flush_o, fpu_rsp_ready_o;
    logic [PW-1:0] fpu_payload_o;
    logic [1:0]    fpu_tag_o;
    logic          rsp_valid_o, busy_o, tag_err_o;
    logic [63:0]   rsp_result_o;
    logic [4:0]    rsp_status_o;
    logic [2:0]    count_o;

    fpnew_rob #(.WIDTH(64), .DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_payload_i(payload),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready),
        .fpu_payload_o(fpu_payload_o), .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
        .fpu_rsp_valid_i(fpu_rsp_valid), .fpu_rsp_ready_o(fpu_rsp_ready_o),
        .fpu_result_i(fres), .fpu_status_i(fst), .fpu_tag_i(ftag),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
        .count_o(count_o), .busy_o(busy_o), .tag_err_o(tag_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // In-order model: one queue element per outstanding operation, oldest first.
    typedef struct {
        int          tag;
        bit          done;
        logic [63:0] res;
        logic [4:0]  st;
    } ent_t;
    ent_t mq[$];
    int   next_tag = 0;
    bit   m_err = 1'b0;

    typedef struct {
        logic rst, flush, rv, fr;
        logic [PW-1:0] pay;
        logic fv;
        logic [1:0] ftag;
        logic [63:0] fres;
        logic [4:0] fst;
        logic rr;
        logic e_rr, e_fv;
        logic [1:0] e_tag;
        logic e_rv;
        logic [63:0] e_res;
        logic [4:0] e_st;
        logic [2:0] e_cnt;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit full, efv, erv;
        full = (mq.size() == DEPTH);
        efv  = req_valid && !full && !flush && !rst;
        chk("req_ready", req_ready_o, fpu_ready && !full && !flush && !rst);
        chk("fpu_valid", fpu_valid_o, efv);
        if (efv) begin
            chk("fpu_tag", fpu_tag_o, next_tag);
            chk("fpu_payload", fpu_payload_o, payload);
        end
        chk("fpu_flush", fpu_flush_o, flush);
        chk("fpu_rsp_ready", fpu_rsp_ready_o, 1'b1);
        erv = !rst && !flush && (mq.size() > 0) && mq[0].done;
        chk("rsp_valid", rsp_valid_o, erv);
        if (erv) begin
            chk("rsp_result", rsp_result_o, mq[0].res);
            chk("rsp_status", rsp_status_o, mq[0].st);
        end
        chk("count", count_o, mq.size());
        chk("busy", busy_o, mq.size() != 0);
        chk("tag_err", tag_err_o, m_err);
    endtask

    task automatic model_edge();
        bit do_issue, do_out, found;
        do_issue = !rst && !flush && req_valid && fpu_ready && (mq.size() < DEPTH);
        do_out   = !rst && !flush && (mq.size() > 0) && mq[0].done && rsp_ready;
        if (rst) begin
            mq.delete(); next_tag = 0; m_err = 1'b0;
        end else if (flush) begin
            mq.delete(); next_tag = 0;
        end else begin
            if (fpu_rsp_valid) begin
                found = 1'b0;
                foreach (mq[i]) begin
                    if (mq[i].tag == int'(ftag) && !mq[i].done) begin
                        mq[i].done = 1'b1; mq[i].res = fres; mq[i].st = fst; found = 1'b1;
                    end
                end
                if (!found) m_err = 1'b1;
            end
            if (do_out) void'(mq.pop_front());
            if (do_issue) begin
                mq.push_back('{tag: next_tag, done: 1'b0, res: 64'h0, st: 5'h0});
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
    endtask

    task automatic cycle(input bit check);
        #1;
        if (check) model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; req_valid = 1'b0; fpu_ready = 1'b1; payload = '0;
        fpu_rsp_valid = 1'b0; ftag = 2'd0; fres = 64'h0; fst = 5'h0; rsp_ready = 1'b0;
    endtask

    task automatic respond(input int t, input logic [63:0] r, input logic [4:0] s);
        fpu_rsp_valid = 1'b1; ftag = 2'(t); fres = r; fst = s;
    endtask

    function automatic vec_t mk(input logic r, fl, rv, fr, input logic [PW-1:0] pay,
                                input logic fv, input logic [1:0] tg, input logic [63:0] rs,
                                input logic [4:0] st, input logic rr,
                                input logic err, efv, input logic [1:0] etg, input logic erv,
                                input logic [63:0] eres, input logic [4:0] est,
                                input logic [2:0] ecnt);
        vec_t v;
        v.rst = r; v.flush = fl; v.rv = rv; v.fr = fr; v.pay = pay; v.fv = fv; v.ftag = tg;
        v.fres = rs; v.fst = st; v.rr = rr; v.e_rr = err; v.e_fv = efv; v.e_tag = etg;
        v.e_rv = erv; v.e_res = eres; v.e_st = est; v.e_cnt = ecnt;
        return v;
    endfunction

    initial begin
        // Reset, then A,B,C issued and returned as C,A,B; client must see A,B,C.
        tbl[0]  = mk(1'b1,1'b0,1'b0,1'b1,16'h0,1'b0,2'd0,64'h0,5'h0,1'b0, 1'b0,1'b0,2'd0,1'b0,64'h0,5'h0,3'd0);
        tbl[1]  = mk(1'b1,1'b0,1'b0,1'b1,16'h0,1'b0,2'd0,64'h0,5'h0,1'b0, 1'b0,1'b0,2'd0,1'b0,64'h0,5'h0,3'd0);
        tbl[2]  = mk(1'b0,1'b0,1'b1,1'b1,16'hA,1'b0,2'd0,64'h0,5'h0,1'b0, 1'b1,1'b1,2'd0,1'b0,64'h0,5'h0,3'd0);
        tbl[3]  = mk(1'b0,1'b0,1'b1,1'b1,16'hB,1'b0,2'd0,64'h0,5'h0,1'b0, 1'b1,1'b1,2'd1,1'b0,64'h0,5'h0,3'd1);
        tbl[4]  = mk(1'b0,1'b0,1'b1,1'b1,16'hC,1'b0,2'd0,64'h0,5'h0,1'b0, 1'b1,1'b1,2'd2,1'b0,64'h0,5'h0,3'd2);
        tbl[5]  = mk(1'b0,1'b0,1'b0,1'b1,16'h0,1'b1,2'd2,64'hC0C0,5'h01,1'b0, 1'b1,1'b0,2'd0,1'b0,64'h0,5'h0,3'd3);
        tbl[6]  = mk(1'b0,1'b0,1'b0,1'b1,16'h0,1'b1,2'd0,64'hA0A0,5'h10,1'b0, 1'b1,1'b0,2'd0,1'b0,64'h0,5'h0,3'd3);
        tbl[7]  = mk(1'b0,1'b0,1'b0,1'b1,16'h0,1'b1,2'd1,64'hB0B0,5'h04,1'b1, 1'b1,1'b0,2'd0,1'b1,64'hA0A0,5'h10,3'd3);
        tbl[8]  = mk(1'b0,1'b0,1'b0,1'b1,16'h0,1'b0,2'd0,64'h0,5'h0,1'b1, 1'b1,1'b0,2'd0,1'b1,64'hB0B0,5'h04,3'd2);
        tbl[9]  = mk(1'b0,1'b0,1'b0,1'b1,16'h0,1'b0,2'd0,64'h0,5'h0,1'b1, 1'b1,1'b0,2'd0,1'b1,64'hC0C0,5'h01,3'd1);
        tbl[10] = mk(1'b0,1'b0,1'b0,1'b1,16'h0,1'b0,2'd0,64'h0,5'h0,1'b1, 1'b1,1'b0,2'd0,1'b0,64'h0,5'h0,3'd0);

        idle(); rst = 1'b1;
        cycle(1'b0);
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; flush = tbl[i].flush; req_valid = tbl[i].rv; fpu_ready = tbl[i].fr;
            payload = tbl[i].pay; fpu_rsp_valid = tbl[i].fv; ftag = tbl[i].ftag;
            fres = tbl[i].fres; fst = tbl[i].fst; rsp_ready = tbl[i].rr;
            #1;
            chk("tbl_req_ready", req_ready_o, tbl[i].e_rr);
            chk("tbl_fpu_valid", fpu_valid_o, tbl[i].e_fv);
            if (tbl[i].e_fv) chk("tbl_fpu_tag", fpu_tag_o, tbl[i].e_tag);
            chk("tbl_rsp_valid", rsp_valid_o, tbl[i].e_rv);
            if (tbl[i].e_rv) begin
                chk("tbl_rsp_result", rsp_result_o, tbl[i].e_res);
                chk("tbl_rsp_status", rsp_status_o, tbl[i].e_st);
            end
            chk("tbl_count", count_o, tbl[i].e_cnt);
            model_check();
            @(posedge clk);
            model_edge();
            #1;
        end

        // Fill to capacity, free tag 0 and reissue it only on the following cycle.
        idle(); flush = 1'b1; cycle(1'b1);
        idle(); req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin payload = 16'(i + 16'h100); cycle(1'b1); end
        chk("fill_count", count_o, 3'd4);
        chk("fill_ready", req_ready_o, 1'b0);
        req_valid = 1'b0; respond(0, 64'h1111, 5'h02); cycle(1'b1);
        idle(); req_valid = 1'b1; rsp_ready = 1'b1; payload = 16'h0200;
        chk("wrap_blocked", fpu_valid_o, 1'b0);
        cycle(1'b1);
        chk("wrap_tag", fpu_tag_o, 2'd0);
        cycle(1'b1);

        // Response held while the client stalls; issue keeps trying.
        idle(); req_valid = 1'b1; respond(1, 64'h2222, 5'h08); cycle(1'b1);
        idle(); req_valid = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b1);
        idle(); rsp_ready = 1'b1; respond(2, 64'h3333, 5'h00); cycle(1'b1);
        respond(3, 64'h4444, 5'h1F); cycle(1'b1);
        respond(0, 64'h5555, 5'h03); cycle(1'b1);
        fpu_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1);

        // Random traffic; responses only for tags the model holds as pending.
        for (int n = 0; n < 1500; n++) begin
            int pend[$];
            idle();
            req_valid = 1'($urandom_range(0, 1));
            fpu_ready = ($urandom_range(0, 3) != 0);
            rsp_ready = 1'($urandom_range(0, 1));
            payload   = 16'($urandom);
            flush     = ($urandom_range(0, 63) == 0);
            foreach (mq[i]) if (!mq[i].done) pend.push_back(mq[i].tag);
            if (pend.size() > 0 && $urandom_range(0, 2) != 0)
                respond(pend[$urandom_range(0, pend.size() - 1)], {$urandom, $urandom}, 5'($urandom));
            cycle(1'b1);
        end

        // Stale tag raises a sticky error and leaves entries untouched.
        idle(); flush = 1'b1; cycle(1'b1);
        idle(); req_valid = 1'b1; cycle(1'b1); cycle(1'b1);
        idle(); respond(3, 64'hDEAD, 5'h1F); cycle(1'b1);
        chk("tag_err_set", tag_err_o, 1'b1);
        chk("tag_err_count", count_o, 3'd2);
        idle(); rsp_ready = 1'b1; respond(0, 64'h6666, 5'h01); cycle(1'b1);
        respond(1, 64'h7777, 5'h02); cycle(1'b1);
        fpu_rsp_valid = 1'b0; cycle(1'b1); cycle(1'b1);

        // Flush with two pending and one done entry.
        idle(); flush = 1'b1; cycle(1'b1);
        idle(); req_valid = 1'b1; cycle(1'b1); cycle(1'b1); cycle(1'b1);
        idle(); respond(0, 64'h8888, 5'h04); cycle(1'b1);
        idle(); flush = 1'b1;
        #1;
        chk("flush_fwd", fpu_flush_o, 1'b1);
        cycle(1'b1);
        idle();
        chk("flush_count", count_o, 3'd0);
        chk("flush_busy", busy_o, 1'b0);
        req_valid = 1'b1; #1;
        chk("flush_tag", fpu_tag_o, 2'd0);
        cycle(1'b1);

        // Reset clears the sticky error.
        idle(); rst = 1'b1; cycle(1'b1);
        idle(); cycle(1'b1);
        chk("reset_tag_err", tag_err_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fpnew_rob.md
# fpnew_rob

Client-side reorder buffer sitting in front of the FPU top level. It issues opaque operation requests into the FPU with a locally allocated tag and captures results as they return. Results can come back out of order because opgroups have different latencies and share a round-robin output arbiter. The block releases results to the client strictly in issue order, so a core can treat the FPU as an in-order, tag-free pipeline.

## Interface
Parameters:
- WIDTH, 64: result width; must equal the FPU datapath width.
- DEPTH, 4: outstanding-operation capacity; power of two, ≥2.
- PAYLOAD_W, 256: width of the opaque request bundle (operands, op, fmt, rnd_mode, …) forwarded untouched.
- TAG_W, $clog2(DEPTH): derived; width of the FPU tag.

Ports:
- clk_i, in, 1: clock; sole clock domain.
- rst_i, in, 1: reset, synchronous, active-high.
- flush_i, in, 1: discard all in-flight and completed entries.
- req_valid_i / req_ready_o, in/out, 1/1: client request handshake.
- req_payload_i, in, PAYLOAD_W: request bundle.
- fpu_valid_o / fpu_ready_i, out/in, 1/1: FPU input handshake.
- fpu_payload_o, out, PAYLOAD_W: forwarded request bundle.
- fpu_tag_o, out, TAG_W: allocated entry index.
- fpu_flush_o, out, 1: flush forwarded to the FPU.
- fpu_rsp_valid_i / fpu_rsp_ready_o, in/out, 1/1: FPU output handshake.
- fpu_result_i, in, WIDTH: FPU result.
- fpu_status_i, in, 5: FPU exception flags {NV,DZ,OF,UF,NX}.
- fpu_tag_i, in, TAG_W: returned tag.
- rsp_valid_o / rsp_ready_i, out/in, 1/1: in-order client response handshake.
- rsp_result_o, out, WIDTH: result of the oldest entry.
- rsp_status_o, out, 5: flags of the oldest entry.
- count_o, out, TAG_W+1: occupancy.
- busy_o, out, 1: count_o != 0.
- tag_err_o, out, 1: sticky; set by a response carrying a tag that is not pending.

## Operation
- State: wptr, rptr (TAG_W bits, natural wrap), count (TAG_W+1), per-entry pending/done bits, result/status arrays.
- Entry lifecycle: FREE → PENDING (issued) → DONE (result captured) → FREE (handed to client).
- Issue path is combinational and has zero latency:
  - fpu_valid_o = req_valid_i & !full & !flush_i.
  - req_ready_o = fpu_ready_i & !full & !flush_i.
  - fpu_payload_o = req_payload_i; fpu_tag_o = wptr.
  - full = (count == DEPTH).
  - fpu_valid_o must not depend on fpu_ready_i, because the FPU's ready depends on valid.
- Issue handshake (fpu_valid_o & fpu_ready_i): pending[wptr] ← 1, wptr ← wptr+1.
- fpu_rsp_ready_o is constant 1; space was reserved at issue.
- Response capture (fpu_rsp_valid_i & !flush_i & pending[fpu_tag_i]):
  - result/status[tag] ← inputs.
  - pending ← 0, done ← 1.
- Response with a non-pending tag and no flush: data discarded, tag_err_o ← 1; cleared only by rst_i.
- Output: rsp_valid_o = done[rptr] & !flush_i; rsp_result_o and rsp_status_o read from entry rptr.
- Output handshake: done[rptr] ← 0, rptr ← rptr+1.
- count update: +1 on issue, −1 on output handshake, unchanged when both occur.
- full is evaluated on the pre-update count, so a slot freed this cycle is reusable next cycle.
- Flush:
  - fpu_flush_o = flush_i, combinational.
  - Next cycle: all pending/done bits 0, wptr = rptr = 0, count = 0.
  - During the flush cycle, issue and output are blocked and FPU responses are ignored without raising tag_err_o.
- Reset: same clearing as flush, plus tag_err_o ← 0. Result/status arrays need not be reset.

## Timing
- Issue adds 0 cycles.
- FPU response to rsp_valid_o: exactly 1 cycle, because there is no bypass from capture to output.
- Reset values: req_ready_o = 0 while rst_i is high; fpu_valid_o 0, rsp_valid_o 0, count_o 0, busy_o 0, tag_err_o 0, fpu_flush_o follows flush_i.
- rsp_result_o and rsp_status_o are held stable while rsp_valid_o & !rsp_ready_i.
- Simultaneous events in one cycle:
  - Issue, capture and output in any combination are legal.
  - A capture and an output on the same entry cannot coincide, since the output requires done to be already set.
- Reset or flush mid-operation: entries are dropped immediately. A late FPU response after a flush is not masked; it either raises tag_err_o or hits a freshly allocated tag, so the FPU must honour fpu_flush_o.

## Test plan
- Reset with rst_i held 3 cycles, fpu_ready_i=1 → req_ready_o=0 during reset; count_o=0, rsp_valid_o=0, tag_err_o=0.
- Issue ops A, B, C (tags 0, 1, 2); FPU returns C, A, B on consecutive cycles → client sees A, B, C in order; A appears 1 cycle after its capture.
- Fill to DEPTH=4, no responses → req_ready_o=0, fpu_valid_o=0, count_o=4. Return tag 0 and accept it; on the same cycle as the output handshake, req_valid_i=1 → blocked that cycle, issued the next cycle with tag 0 (wrap-around).
- rsp_ready_i=0 for 5 cycles with rsp_valid_o=1 → rsp_result_o/rsp_status_o stable. Issue continues until full.
- Response with tag 3 while only tags 0 and 1 are pending → tag_err_o=1, no entry changes, stays 1 across later traffic.
- Two pending and one done entry, assert flush_i for 1 cycle → fpu_flush_o=1 that cycle; next cycle count_o=0, busy_o=0, and the next issue gets tag 0.
